sipo_frame_rx: RTL and testbench
================================

# sipo_frame_rx

Framed serial-to-parallel receiver that consumes the one-bit-per-clock stream leaving the N-bit SISO shift-register stage (its `q_out` drives our `d_in`). It detects a start bit, shifts in N data bits LSB first, checks optional parity and the stop bit, then presents the word on a one-deep valid/ready output buffer. Framing, parity and overrun errors are reported as single-cycle pulses.

## Interface
- `N`, default 8: data bits per frame (N ≥ 2).
- `PARITY_EN`, default 1: 1 = frame carries a parity bit after the data bits; 0 = no parity bit.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Ignored when `PARITY_EN` = 0.
- `clk`  in  1  single clock; all sampling on rising edge.
- `reset_al_in`  in  1  asynchronous, active-low reset.
- `d_in`  in  1  serial input, one bit per clock, idle level 1.
- `data_out`  out  N  received word; stable while `valid_out` = 1.
- `valid_out`  out  1  `data_out` holds an unconsumed word.
- `ready_in`  in  1  consumer accepts the word on a rising edge where `valid_out` = `ready_in` = 1.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `parity_err`  out  1  one-cycle pulse: parity mismatch.
- `overrun`  out  1  one-cycle pulse: good word dropped because the buffer was full.

## Operation
- Reset (asynchronous, while `reset_al_in` = 0): state IDLE, bit counter 0, shift register 0, `data_out` 0, `valid_out` 0, all error pulses 0. Reset mid-frame discards the partial word. Reset with a word held discards that word.
- FSM states: IDLE, DATA, PAR, STOP.
  - IDLE: `d_in` = 0 (start bit) → DATA, counter ← 0. `d_in` = 1 → stay in IDLE.
  - DATA: shift register ← {`d_in`, shreg[N-1:1]}, so LSB arrives first. Counter increments each cycle. On counter = N-1 → PAR if `PARITY_EN`, else STOP.
  - PAR: the sampled bit must equal XOR(data bits) ^ `PARITY_ODD`. Store the result as a mismatch flag. → STOP.
  - STOP: always → IDLE.
    - `d_in` = 0 → `frame_err` pulse, word discarded. `parity_err` is not raised for this frame: frame error takes priority.
    - `d_in` = 1 with parity mismatch → `parity_err` pulse, word discarded.
    - `d_in` = 1 and parity OK → commit.
- A 0 sampled in STOP is never treated as a new start bit. Start detection resumes in IDLE on the next cycle.
- Commit:
  - Buffer empty, or the word is being accepted on the same edge (`valid_out` & `ready_in`) → `data_out` ← word, `valid_out` ← 1.
  - Otherwise → `overrun` pulse. The held word and `valid_out` are unchanged, and the new word is dropped.
- Accept without commit: `valid_out` ← 0 and `data_out` holds its value.
- `ready_in` is ignored while `valid_out` = 0.

## Timing
- Start bit sampled at edge E.
- Data bit i is sampled at edge E+1+i.
- Parity bit is sampled at E+N+1. Stop bit is sampled at E+N+2 with parity, E+N+1 without.
- `valid_out` and `data_out` update at the stop-bit edge. They are visible in the following cycle.
- Frame length: N+3 cycles (N+2 without parity).
- Back-to-back frames: a start bit may arrive on the cycle right after the stop bit with no idle gap.
- Error/overrun pulses are asserted for exactly the one cycle after the stop-bit edge.
- Consumer-side throughput: one word per cycle possible; no bubble when accept and commit coincide.

## Test plan
- Even parity, N=8: idle 1s, then 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1 → after stop edge `data_out` = 0xA5, `valid_out` = 1, no error pulses. Hold `ready_in` = 1 for one edge → `valid_out` = 0.
- Same frame with parity bit 1 → `parity_err` pulses for 1 cycle, `valid_out` stays 0. Same frame with stop bit 0 → `frame_err` pulse only, then IDLE. A following correct frame for 0x3C is received normally.
- `ready_in` = 0: send 0x11 then 0x22 back-to-back → `data_out` = 0x11 held, `overrun` pulses at the 0x22 stop edge. Then set `ready_in` = 1 → `valid_out` drops.
- `ready_in` held 1: send 0x11, 0x22, 0x33 back-to-back → each word appears for one accept cycle, no `overrun`, words in order.
- Assert `reset_al_in` = 0 asynchronously mid-DATA (after 4 data bits) and mid-clock → all outputs 0 immediately. Release, send 0xFF → received as 0xFF with parity 0 (even).
- `PARITY_EN` = 0, `PARITY_ODD` = 1 instance: send 0x80 → `valid_out` rises after edge E+9. Odd-parity instance with 0x80 and parity bit 0 → accepted.

Source files
------------

// File: rtl/sipo_frame_rx.sv
// Purpose : framed serial-to-parallel receiver (start, N data bits LSB first, optional parity, stop)
// Latency : word appears on data_out/valid_out the cycle after the stop-bit edge
// Backpres: one-deep output buffer; a good word arriving while the buffer is full is dropped (overrun pulse)
//
// Ports:
//   clk          rising-edge clock
//   reset_al_in  asynchronous active-low reset
//   d_in         serial input, idle high, one bit per clock
//   data_out     received word, stable while valid_out is high
//   valid_out    data_out holds an unconsumed word
//   ready_in     consumer accepts when valid_out && ready_in on a rising edge
//   frame_err    one-cycle pulse: stop bit sampled low
//   parity_err   one-cycle pulse: parity mismatch (suppressed by a framing error)
//   overrun      one-cycle pulse: good word dropped because the buffer was full
module sipo_frame_rx #(
    parameter int N          = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk,
    input  logic         reset_al_in,
    input  logic         d_in,
    output logic [N-1:0] data_out,
    output logic         valid_out,
    input  logic         ready_in,
    output logic         frame_err,
    output logic         parity_err,
    output logic         overrun
);

    localparam int          CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic        ODD      = (PARITY_ODD != 0);
    localparam logic        HAS_PAR  = (PARITY_EN != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  shreg;
    logic          par_bad;   // parity mismatch seen for the frame in flight

    logic accept;
    logic commit;
    logic par_exp;

    assign accept  = valid_out & ready_in;
    // A frame is good only when the stop bit is high and parity (if any) matched.
    assign commit  = (state == S_STOP) & d_in & ~par_bad;
    assign par_exp = (^shreg) ^ ODD;

    // Frame sequencer: start detect, data shift, parity check, stop check.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state      <= S_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!d_in) begin
                        state   <= S_DATA;
                        cnt     <= '0;
                        par_bad <= 1'b0;
                    end
                end
                S_DATA: begin
                    // LSB arrives first, so shift right and insert at the top.
                    shreg <= {d_in, shreg[N-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= HAS_PAR ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    par_bad <= (d_in != par_exp);
                    state   <= S_STOP;
                end
                S_STOP: begin
                    // A low stop bit is a framing error, never a new start bit;
                    // framing error hides any parity error on the same frame.
                    state <= S_IDLE;
                    if (!d_in) begin
                        frame_err <= 1'b1;
                    end else if (par_bad) begin
                        parity_err <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // One-deep output buffer. Loading is allowed when empty or when the held
    // word leaves on this same edge, so back-to-back accepts have no bubble.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit && (!valid_out || ready_in)) begin
                data_out  <= shreg;
                valid_out <= 1'b1;
            end else begin
                if (commit) begin
                    overrun <= 1'b1;
                end
                if (accept) begin
                    valid_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Purpose : self-checking bench for sipo_frame_rx (even, no-parity and odd-parity instances)
// Latency : checks word/pulse timing relative to the stop-bit edge
// Backpres: drives ready_in low/high to exercise hold, accept and overrun
module tb_sipo_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_al_in;

    // main instance: N=8, even parity
    logic       d_m, ready_m, valid_m, fe_m, pe_m, ov_m;
    logic [7:0] dout_m;
    // no parity, PARITY_ODD=1 (ignored)
    logic       d_np, ready_np, valid_np, fe_np, pe_np, ov_np;
    logic [7:0] dout_np;
    // odd parity
    logic       d_od, ready_od, valid_od, fe_od, pe_od, ov_od;
    logic [7:0] dout_od;

    sipo_frame_rx #(.N(8), .PARITY_EN(1), .PARITY_ODD(0)) u_main (
        .clk(clk), .reset_al_in(reset_al_in), .d_in(d_m), .data_out(dout_m),
        .valid_out(valid_m), .ready_in(ready_m), .frame_err(fe_m),
        .parity_err(pe_m), .overrun(ov_m));

    sipo_frame_rx #(.N(8), .PARITY_EN(0), .PARITY_ODD(1)) u_np (
        .clk(clk), .reset_al_in(reset_al_in), .d_in(d_np), .data_out(dout_np),
        .valid_out(valid_np), .ready_in(ready_np), .frame_err(fe_np),
        .parity_err(pe_np), .overrun(ov_np));

    sipo_frame_rx #(.N(8), .PARITY_EN(1), .PARITY_ODD(1)) u_od (
        .clk(clk), .reset_al_in(reset_al_in), .d_in(d_od), .data_out(dout_od),
        .valid_out(valid_od), .ready_in(ready_od), .frame_err(fe_od),
        .parity_err(pe_od), .overrun(ov_od));

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] EV_FE = 3'b100;
    localparam logic [2:0] EV_PE = 3'b010;
    localparam logic [2:0] EV_OV = 3'b001;

    logic [7:0] exp_w[$];
    logic [2:0] exp_e[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted word and every error pulse must match the
    // next expectation pushed by the stimulus.
    always @(negedge clk) begin
        if (reset_al_in) begin
            if (valid_m && ready_m) begin
                if (exp_w.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", dout_m);
                end else begin
                    chk("word", {24'd0, dout_m}, {24'd0, exp_w.pop_front()});
                end
            end
            if ({fe_m, pe_m, ov_m} != 3'b000) begin
                if (exp_e.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got %b expected none", {fe_m, pe_m, ov_m});
                end else begin
                    chk("pulse", {29'd0, fe_m, pe_m, ov_m}, {29'd0, exp_e.pop_front()});
                end
            end
        end
    end

    // Drive one bit on the chosen instance for one clock; returns 1 time unit after the edge.
    task automatic drive(input int inst, input logic b);
        case (inst)
            0:       d_m  = b;
            1:       d_np = b;
            default: d_od = b;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int inst, input logic [7:0] w, input logic use_par,
                        input logic par_bit, input logic stop);
        drive(inst, 1'b0);
        for (int i = 0; i < 8; i++) drive(inst, w[i]);
        if (use_par) drive(inst, par_bit);
        drive(inst, stop);
        case (inst)
            0:       d_m  = 1'b1;
            1:       d_np = 1'b1;
            default: d_od = 1'b1;
        endcase
    endtask

    initial begin
        reset_al_in = 1'b0;
        d_m = 1'b1; d_np = 1'b1; d_od = 1'b1;
        ready_m = 1'b0; ready_np = 1'b0; ready_od = 1'b0;
        #1;
        chk("rst_valid", {31'd0, valid_m}, 32'd0);
        chk("rst_data", {24'd0, dout_m}, 32'd0);
        chk("rst_pulses", {29'd0, fe_m, pe_m, ov_m}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_al_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 0xA5, even parity 0, good stop; held until one accept edge
        exp_w.push_back(8'hA5);
        send(0, 8'hA5, 1'b1, 1'b0, 1'b1);
        chk("a5_valid", {31'd0, valid_m}, 32'd1);
        chk("a5_data", {24'd0, dout_m}, 32'hA5);
        ready_m = 1'b1;
        @(posedge clk);
        #1;
        ready_m = 1'b0;
        chk("a5_drop", {31'd0, valid_m}, 32'd0);
        chk("a5_hold_data", {24'd0, dout_m}, 32'hA5);

        // bad parity, then bad stop (frame error only), then good 0x3C
        ready_m = 1'b1;
        exp_e.push_back(EV_PE);
        send(0, 8'hA5, 1'b1, 1'b1, 1'b1);
        chk("perr_now", {31'd0, pe_m}, 32'd1);
        chk("perr_no_word", {31'd0, valid_m}, 32'd0);
        exp_e.push_back(EV_FE);
        send(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        chk("ferr_now", {29'd0, fe_m, pe_m, ov_m}, {29'd0, EV_FE});
        exp_w.push_back(8'h3C);
        send(0, 8'h3C, 1'b1, 1'b0, 1'b1);
        chk("3c_valid", {31'd0, valid_m}, 32'd1);
        @(posedge clk);
        #1;

        // overrun: ready low, 0x11 then 0x22 back-to-back
        ready_m = 1'b0;
        exp_w.push_back(8'h11);
        exp_e.push_back(EV_OV);
        send(0, 8'h11, 1'b1, 1'b0, 1'b1);
        send(0, 8'h22, 1'b1, 1'b0, 1'b1);
        chk("ovr_pulse", {31'd0, ov_m}, 32'd1);
        chk("ovr_held", {24'd0, dout_m}, 32'h11);
        ready_m = 1'b1;
        @(posedge clk);
        #1;
        chk("ovr_drained", {31'd0, valid_m}, 32'd0);

        // streaming with ready held high: no overrun, in order
        exp_w.push_back(8'h11);
        exp_w.push_back(8'h22);
        exp_w.push_back(8'h33);
        send(0, 8'h11, 1'b1, 1'b0, 1'b1);
        send(0, 8'h22, 1'b1, 1'b0, 1'b1);
        send(0, 8'h33, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("stream_idle", {31'd0, valid_m}, 32'd0);

        // reset mid-DATA while a word is held: everything cleared immediately
        ready_m = 1'b0;
        send(0, 8'h5A, 1'b1, 1'b0, 1'b1);
        chk("5a_held", {31'd0, valid_m}, 32'd1);
        drive(0, 1'b0);
        drive(0, 1'b1);
        drive(0, 1'b0);
        drive(0, 1'b1);
        drive(0, 1'b1);
        #2;
        reset_al_in = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid_m}, 32'd0);
        chk("arst_data", {24'd0, dout_m}, 32'd0);
        chk("arst_pulses", {29'd0, fe_m, pe_m, ov_m}, 32'd0);
        d_m = 1'b1;
        @(posedge clk);
        #1;
        reset_al_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ready_m = 1'b1;
        exp_w.push_back(8'hFF);
        send(0, 8'hFF, 1'b1, 1'b0, 1'b1);
        chk("ff_data", {24'd0, dout_m}, 32'hFF);
        @(posedge clk);
        #1;

        // no-parity instance: valid rises after E+9, not before
        drive(1, 1'b0);                       // edge E
        for (int i = 0; i < 8; i++) drive(1, (i == 7));
        chk("np_not_yet", {31'd0, valid_np}, 32'd0);
        drive(1, 1'b1);                       // stop at E+9
        chk("np_valid", {31'd0, valid_np}, 32'd1);
        chk("np_data", {24'd0, dout_np}, 32'h80);
        chk("np_pulses", {29'd0, fe_np, pe_np, ov_np}, 32'd0);

        // odd parity: 0x80 with parity bit 0 is good; parity bit 1 is an error
        send(2, 8'h80, 1'b1, 1'b0, 1'b1);
        chk("od_valid", {31'd0, valid_od}, 32'd1);
        chk("od_data", {24'd0, dout_od}, 32'h80);
        chk("od_ok_pulses", {29'd0, fe_od, pe_od, ov_od}, 32'd0);
        send(2, 8'h80, 1'b1, 1'b1, 1'b1);
        chk("od_perr", {29'd0, fe_od, pe_od, ov_od}, 32'b010);
        @(posedge clk);
        #1;
        chk("od_perr_1cyc", {31'd0, pe_od}, 32'd0);

        repeat (5) @(posedge clk);
        #1;
        chk("words_left", exp_w.size(), 32'd0);
        chk("pulses_left", exp_e.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
